// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end:
// instruction word, fetch exception code and buffer entry.
package fetch_unit_pkg;

    localparam int INSTR_BYTES = 4;

    typedef logic [31:0] enc_t;

    localparam enc_t OP_NOP = 32'h0000_0000;

    typedef enum logic {
        EX_NONE  = 1'b0,
        EX_FETCH = 1'b1
    } ex_t;

    typedef struct packed {
        enc_t        enc;
        logic [31:0] pc;
        ex_t         ex;
    } entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO used as the fetch instruction buffer.
// Push on full is accepted only when a pop happens in the same cycle.
module fetch_unit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents are only observed through a valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, request credits, stale-response
// dropping after redirects, and the buffer toward the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output enc_t        out_enc,
    output logic [31:0] out_pc,
    output ex_t         out_ex
);

    localparam int FW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = FW + 1;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_base;
    logic [FW-1:0] inflight;
    logic [FW-1:0] drop;
    logic [FW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop;
    entry_t        push_entry;
    entry_t        head_entry;

    assign redirect_base = redirect_pc & ~32'h3;

    // Outstanding plus buffered fetches never exceed the buffer size,
    // so every response always has a slot waiting for it.
    assign credit_ok = !fifo_full
        && (({1'b0, inflight} + {1'b0, fifo_count}) < SW'(BUF_DEPTH));

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop == '0)
                            && !redirect_valid;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Build the buffer entry; a faulted fetch becomes a NOP with EX_FETCH.
    always_comb begin
        push_entry.enc = imem_rsp_data;
        push_entry.pc  = rsp_pc;
        push_entry.ex  = EX_NONE;
        if (imem_rsp_err) begin
            push_entry.enc = OP_NOP;
            push_entry.ex  = EX_FETCH;
        end
    end

    // PC, response PC tracker, in-flight and drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_base;
            rsp_pc   <= redirect_base;
            inflight <= inflight - FW'(imem_rsp_valid);
            drop     <= inflight - FW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'(INSTR_BYTES);
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'(INSTR_BYTES);
            end
            inflight <= inflight + FW'(req_fire) - FW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop != '0)) begin
                drop <= drop - FW'(1);
            end
        end
    end

    fetch_unit_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Decoder-facing fields read as zero while the buffer is empty.
    always_comb begin
        out_enc = '0;
        out_pc  = '0;
        out_ex  = EX_NONE;
        if (out_valid) begin
            out_enc = head_entry.enc;
            out_pc  = head_entry.pc;
            out_ex  = head_entry.ex;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_fetch_unit;

    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    enc_t        out_enc;
    logic [31:0] out_pc;
    ex_t         out_ex;

    fetch_unit #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_enc        (out_enc),
        .out_pc         (out_pc),
        .out_ex         (out_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } fl_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    // reference model: fetches in flight, buffered entries, next PC
    fl_t         mq[$];
    entry_t      bq[$];
    logic [31:0] mpc;

    // memory model and observation logs
    mreq_t       memq[$];
    logic [31:0] fire_log[$];
    entry_t      out_log[$];

    int          cyc;
    int          vectors;
    int          errors;
    int          lat_min;
    int          lat_max;
    logic [31:0] err_addr;
    bit          rand_err;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic bit mem_err(logic [31:0] a);
        return (a == err_addr) || (rand_err && (a[6:2] == 5'd13));
    endfunction

    function automatic entry_t model_entry(logic [31:0] p);
        entry_t e;
        e.pc  = p;
        e.enc = mem_err(p) ? 32'h0 : mem_word(p);
        e.ex  = mem_err(p) ? EX_FETCH : EX_NONE;
        return e;
    endfunction

    function automatic bit e_rv();
        return !rst && !redirect_valid
            && ((mq.size() + bq.size()) < DEPTH);
    endfunction

    function automatic entry_t e_head();
        entry_t e;
        e = '0;
        if (bq.size() > 0) e = bq[0];
        return e;
    endfunction

    // one clock: update model and memory from this cycle's inputs,
    // then advance to the next falling edge and drive the response
    task automatic tick();
        bit          m_fire;
        bit          m_pop;
        bit          d_fire;
        logic [31:0] d_addr;
        fl_t         f;
        entry_t      e;
        #1;
        m_fire = e_rv() && imem_req_ready;
        m_pop  = (bq.size() > 0) && out_ready;
        d_fire = imem_req_valid && imem_req_ready;
        d_addr = imem_req_addr;
        if (d_fire) fire_log.push_back(d_addr);
        if (out_valid && out_ready) begin
            e.enc = out_enc;
            e.pc  = out_pc;
            e.ex  = out_ex;
            out_log.push_back(e);
        end
        if (rst) begin
            mq.delete();
            bq.delete();
            memq.delete();
            mpc = RPC;
        end else begin
            if (m_pop) void'(bq.pop_front());
            if (imem_rsp_valid && mq.size() > 0) begin
                f = mq.pop_front();
                if (!f.stale && !redirect_valid)
                    bq.push_back(model_entry(f.pc));
            end
            if (redirect_valid) begin
                bq.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                mpc = redirect_pc & ~32'h3;
            end else if (m_fire) begin
                mq.push_back('{pc: mpc, stale: 1'b0});
                mpc = mpc + 32'd4;
            end
            if (imem_rsp_valid && memq.size() > 0)
                void'(memq.pop_front());
            if (d_fire)
                memq.push_back('{addr: d_addr,
                    due: cyc + int'($urandom_range(lat_min, lat_max))});
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
            imem_rsp_err   = mem_err(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        fire_log.delete();
        out_log.delete();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_valid got=%b want=0", imem_req_valid);
        end
        vectors++;
        if (imem_req_addr !== RPC) begin
            errors++;
            $display("FAIL rst_addr got=%h want=%h", imem_req_addr, RPC);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got=%b want=0", out_valid);
        end
        vectors++;
        if (out_enc !== 32'h0 || out_pc !== 32'h0
            || out_ex !== EX_NONE) begin
            errors++;
            $display("FAIL rst_out_fields got=%h/%h/%0d want=0/0/0",
                out_enc, out_pc, out_ex);
        end
        tick();
        rst = 1'b0;
        fire_log.delete();
        out_log.delete();
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            errors++;
            $display("FAIL first_req got=%b/%h want=1/%h",
                imem_req_valid, imem_req_addr, RPC);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_out_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_stream();
        int first_out;
        first_out = -1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid === 1'b1 && first_out < 0) first_out = k;
            tick();
        end
        vectors++;
        if (first_out != 2) begin
            errors++;
            $display("FAIL stream_latency got=R+%0d want=R+2", first_out);
        end
        vectors++;
        if (fire_log.size() < 3 || out_log.size() < 3) begin
            errors++;
            $display("FAIL stream_count got=%0d/%0d want>=3/3",
                fire_log.size(), out_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (fire_log[i] !== RPC + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL stream_req%0d got=%h want=%h",
                        i, fire_log[i], RPC + 32'(4 * i));
                end
                vectors++;
                if (out_log[i].pc !== RPC + 32'(4 * i)
                    || out_log[i].enc !== mem_word(RPC + 32'(4 * i))) begin
                    errors++;
                    $display("FAIL stream_out%0d got=%h/%h want=%h/%h",
                        i, out_log[i].pc, out_log[i].enc,
                        RPC + 32'(4 * i), mem_word(RPC + 32'(4 * i)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        lat_min = 1;
        lat_max = 1;
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        do_reset();
        repeat (10) tick();
        #1;
        vectors++;
        if (fire_log.size() != DEPTH || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_issue got=%0d/%b want=%0d/0",
                fire_log.size(), imem_req_valid, DEPTH);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== RPC) begin
            errors++;
            $display("FAIL bp_head got=%b/%h want=1/%h",
                out_valid, out_pc, RPC);
        end
        out_ready = 1'b1;
        out_log.delete();
        repeat (14) tick();
        vectors++;
        if (out_log.size() < 5) begin
            errors++;
            $display("FAIL bp_drain got=%0d want>=5", out_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (out_log[i].pc !== RPC + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL bp_order%0d got=%h want=%h",
                        i, out_log[i].pc, RPC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect();
        lat_min = 3;
        lat_max = 3;
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2003;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_no_req got=%b want=0", imem_req_valid);
        end
        vectors++;
        if (fire_log.size() != 2) begin
            errors++;
            $display("FAIL redir_inflight got=%0d want=2", fire_log.size());
        end
        tick();
        redirect_valid = 1'b0;
        lat_min = 1;
        lat_max = 1;
        fire_log.delete();
        out_log.delete();
        repeat (15) tick();
        vectors++;
        if (fire_log.size() < 1 || fire_log[0] !== 32'h2000) begin
            errors++;
            $display("FAIL redir_addr got=%h want=00002000",
                fire_log.size() > 0 ? fire_log[0] : 32'hx);
        end
        vectors++;
        if (out_log.size() < 1 || out_log[0].pc !== 32'h2000
            || out_log[0].enc !== mem_word(32'h2000)) begin
            errors++;
            $display("FAIL redir_out got=%h want=00002000",
                out_log.size() > 0 ? out_log[0].pc : 32'hx);
        end
    endtask

    task automatic test_fault();
        lat_min = 1;
        lat_max = 1;
        err_addr = 32'h104;
        out_ready = 1'b1;
        do_reset();
        repeat (12) tick();
        vectors++;
        if (out_log.size() < 3) begin
            errors++;
            $display("FAIL fault_count got=%0d want>=3", out_log.size());
        end else begin
            vectors++;
            if (out_log[0].pc !== 32'h100 || out_log[0].ex !== EX_NONE) begin
                errors++;
                $display("FAIL fault_prev got=%h/%0d want=100/0",
                    out_log[0].pc, out_log[0].ex);
            end
            vectors++;
            if (out_log[1].pc !== 32'h104 || out_log[1].ex !== EX_FETCH
                || out_log[1].enc !== 32'h0) begin
                errors++;
                $display("FAIL fault_slot got=%h/%0d/%h want=104/1/0",
                    out_log[1].pc, out_log[1].ex, out_log[1].enc);
            end
            vectors++;
            if (out_log[2].pc !== 32'h108 || out_log[2].ex !== EX_NONE
                || out_log[2].enc !== mem_word(32'h108)) begin
                errors++;
                $display("FAIL fault_next got=%h/%0d/%h want=108/0/%h",
                    out_log[2].pc, out_log[2].ex, out_log[2].enc,
                    mem_word(32'h108));
            end
        end
        err_addr = 32'h1;
    endtask

    task automatic test_wrap();
        lat_min = 1;
        lat_max = 1;
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        fire_log.delete();
        out_log.delete();
        repeat (10) tick();
        vectors++;
        if (fire_log.size() < 2 || fire_log[0] !== 32'hFFFF_FFFC
            || fire_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr got=%h,%h want=fffffffc,00000000",
                fire_log.size() > 0 ? fire_log[0] : 32'hx,
                fire_log.size() > 1 ? fire_log[1] : 32'hx);
        end
        vectors++;
        if (out_log.size() < 2 || out_log[1].pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_out got=%h want=00000000",
                out_log.size() > 1 ? out_log[1].pc : 32'hx);
        end
    endtask

    task automatic test_reset_midway();
        lat_min = 1;
        lat_max = 1;
        out_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got=%b want=1", out_valid);
        end
        rst = 1'b1;
        tick();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0
            || imem_req_addr !== RPC || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got=%b/%h/%h/%b want=0/0/%h/0",
                out_valid, out_pc, imem_req_addr, imem_req_valid, RPC);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        fire_log.delete();
        out_log.delete();
        repeat (6) tick();
        vectors++;
        if (fire_log.size() < 1 || fire_log[0] !== RPC
            || out_log.size() < 1 || out_log[0].pc !== RPC) begin
            errors++;
            $display("FAIL midrst_restart got=%h/%h want=%h/%h",
                fire_log.size() > 0 ? fire_log[0] : 32'hx,
                out_log.size() > 0 ? out_log[0].pc : 32'hx, RPC, RPC);
        end
    endtask

    task automatic test_random();
        entry_t h;
        bit     rv;
        lat_min = 1;
        lat_max = 3;
        rand_err = 1'b1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            rst            = ($urandom_range(0, 499) == 0);
            #1;
            rv = e_rv();
            h  = e_head();
            vectors++;
            if (imem_req_valid !== rv) begin
                errors++;
                $display("FAIL rnd_req_valid c%0d got=%b want=%b",
                    cyc, imem_req_valid, rv);
            end
            vectors++;
            if (imem_req_addr !== mpc) begin
                errors++;
                $display("FAIL rnd_addr c%0d got=%h want=%h",
                    cyc, imem_req_addr, mpc);
            end
            vectors++;
            if (out_valid !== (bq.size() > 0)) begin
                errors++;
                $display("FAIL rnd_out_valid c%0d got=%b want=%b",
                    cyc, out_valid, bq.size() > 0);
            end
            vectors++;
            if (out_enc !== h.enc || out_pc !== h.pc
                || out_ex !== h.ex) begin
                errors++;
                $display("FAIL rnd_out c%0d got=%h/%h/%0d want=%h/%h/%0d",
                    cyc, out_enc, out_pc, out_ex, h.enc, h.pc, h.ex);
            end
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        rand_err = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        errors         = 0;
        cyc            = 0;
        lat_min        = 1;
        lat_max        = 1;
        err_addr       = 32'h1;
        rand_err       = 1'b0;
        mpc            = RPC;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_reset_midway();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, errors);
        $finish;
    end

endmodule
